uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Frame-level controller for the UART receiver.
- Sequences the 3-sample majority data sampler by driving its enable and oversampling edge count.
- Reads the voted bit back at a fixed point in each bit period and assembles start/data/parity/stop.
- Delivers a parallel byte with a one-cycle valid pulse, plus parity and stop error pulses, to the RX-side consumer (register file / FIFO writer).

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, LSB first.

Ports:
- CLK  input  1  oversampling clock, prescale × baud.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line, already synchronised; idle = 1.
- prescale  input  6  oversampling ratio; 8, 16 or 32, any other value treated as 8; static while a frame is in progress.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- sampled_bit  input  1  majority-voted bit returned by the sampler.
- data_sample_en  output  1  sampler enable.
- edge_cnt  output  5  oversampling edge index within the current bit, 0..prescale-1.
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse, P_DATA updated.
- par_err  output  1  one-cycle pulse, parity mismatch.
- stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (RST=1 at posedge): state IDLE; edge_cnt=0; bit_cnt=0; shift register=0; P_DATA=0; data_sample_en, data_valid, par_err, stp_err all 0. A reset mid-frame aborts the frame with no outputs pulsed.
- Prescale decode, latched into prescale_q on the IDLE→START transition:
  - LAST = prescale_q-1
  - READ = 6 for 8, 10 for 16, 18 for 32
  - The sampler captures at MID-1, MID, MID+1; voted bit is stable from MID+2.
- Counting: outside IDLE, edge_cnt increments every cycle. At LAST it wraps to 0 and bit_cnt increments. In IDLE both are held at 0.
- data_sample_en = 1 in every state except IDLE; registered, asserted from the first START cycle.
- States and transitions:
  - IDLE: RX_IN=0 → START (edge_cnt=0 in the first START cycle).
  - START: at edge_cnt==READ, sampled_bit=1 → false start, IDLE next cycle, no pulses. Otherwise at LAST → DATA with bit_cnt=0.
  - DATA: at edge_cnt==READ, shift sampled_bit in at the MSB, shifting right, so the first bit lands at P_DATA[0]. At LAST with bit_cnt==DATA_WIDTH-1 → PARITY if PAR_EN else STOP.
  - PARITY: at READ, capture perr = sampled_bit XOR (^shift) XOR PAR_TYP. At LAST → STOP.
  - STOP: at READ, serr = ~sampled_bit → IDLE next cycle. Leaving before the end of the stop bit allows a back-to-back start edge to be caught within half a bit.
- Output pulses, on the cycle after the STOP read point:
  - par_err = perr & PAR_EN
  - stp_err = serr
  - data_valid = ~(par_err | stp_err), with P_DATA <= shift in the same cycle.
  - On error, P_DATA keeps its previous value.
  - All three pulses last exactly one cycle.
- Latency: data_valid asserts READ+1 cycles after the stop-bit period starts.
- perr is cleared on entry to START.
- A PAR_EN / PAR_TYP change mid-frame takes effect only at the PARITY or STOP decision; no glitch protection.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state encodings IDLE, START, DATA, PARITY, STOP (3-bit localparams);
  - prescale constants 8/16/32;
  - READ/LAST lookup as a function.
- Sub-module uart_rx_edge_bit_cnt: edge_cnt/bit_cnt counters with enable and wrap at LAST. The FSM and shift/check logic stay in uart_rx_ctrl.
- The bench instantiates uart_rx_ctrl together with the existing sampler.

Test Plan:
- Byte, prescale=8, PAR_EN=0: frame 0xA5 → data_valid one cycle, P_DATA=0xA5, par_err=stp_err=0, data_valid exactly 8·9+7 cycles after the start falling edge.
- Even parity, prescale=16, PAR_EN=1, PAR_TYP=0: 0x3C with parity 0 → valid, P_DATA=0x3C. Same frame with parity 1 → par_err pulse, data_valid=0, P_DATA unchanged.
- Stop error, prescale=32, odd parity: 0x81 with correct parity 1 and stop bit driven 0 → stp_err pulse only, P_DATA unchanged.
- Glitch start: RX_IN low for 2 cycles at prescale=16 → return to IDLE at READ, no pulses, data_sample_en deasserts.
- Back-to-back frames 0x55 then 0xAA with no idle gap → two data_valid pulses with the correct values.
- Reset mid-frame: RST=1 during DATA bit 4 → next cycle all outputs 0, state IDLE. A following clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, prescale
// constants and the per-prescale read/last edge lookup.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Unsupported ratios fall back to 8x oversampling.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

  // Final edge index of a bit period.
  function automatic logic [4:0] last_edge(input logic [5:0] p);
    return 5'(norm_prescale(p) - 6'd1);
  endfunction

  // Edge at which the voted bit is stable: two edges past mid-bit.
  function automatic logic [4:0] read_edge(input logic [5:0] p);
    case (norm_prescale(p))
      PRESCALE_16: return 5'd10;
      PRESCALE_32: return 5'd18;
      default:     return 5'd6;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter for the UART receiver.
module uart_rx_edge_bit_cnt #(
  parameter int unsigned BIT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             bit_clr,
  input  logic [4:0]       last,
  output logic [4:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_cnt
);

  // Count edges within a bit; wrap at last and advance (or clear) the bit count.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == last) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_clr ? '0 : bit_cnt + BIT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame-level UART receive controller: drives the majority sampler, reads
// the voted bit once per bit period and assembles start/data/parity/stop.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_sample_en,
  output logic [4:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 2);

  rx_state_e             state;
  logic [5:0]            prescale_q;
  logic [DATA_WIDTH-1:0] shift;
  logic                  perr;
  logic [BIT_W-1:0]      bit_cnt;
  logic [4:0]            last_e;
  logic [4:0]            read_e;
  logic                  at_read;
  logic                  at_last;
  logic                  false_start;
  logic                  stop_done;
  logic                  cnt_en;

  assign last_e      = last_edge(prescale_q);
  assign read_e      = read_edge(prescale_q);
  assign at_read     = (edge_cnt == read_e);
  assign at_last     = (edge_cnt == last_e);
  assign false_start = (state == START) && at_read && sampled_bit;
  assign stop_done   = (state == STOP) && at_read;
  // Counters clear on the same edge the FSM drops back to IDLE, so they read
  // zero throughout IDLE rather than one stale cycle after an early exit.
  assign cnt_en      = (state != IDLE) && !false_start && !stop_done;

  uart_rx_edge_bit_cnt #(
    .BIT_W (BIT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (cnt_en),
    .bit_clr  (state == START),
    .last     (last_e),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Frame FSM with registered sampler enable, word output and status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      prescale_q     <= '0;
      shift          <= '0;
      perr           <= 1'b0;
      P_DATA         <= '0;
      data_sample_en <= 1'b0;
      data_valid     <= 1'b0;
      par_err        <= 1'b0;
      stp_err        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state          <= START;
            prescale_q     <= norm_prescale(prescale);
            perr           <= 1'b0;
            data_sample_en <= 1'b1;
          end
        end
        START: begin
          if (false_start) begin
            state          <= IDLE;
            data_sample_en <= 1'b0;
          end else if (at_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_read) shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
          if (at_last && bit_cnt == BIT_W'(DATA_WIDTH - 1))
            state <= PAR_EN ? PARITY : STOP;
        end
        PARITY: begin
          if (at_read) perr <= sampled_bit ^ (^shift) ^ PAR_TYP;
          if (at_last) state <= STOP;
        end
        STOP: begin
          if (at_read) begin
            state          <= IDLE;
            data_sample_en <= 1'b0;
            par_err        <= perr & PAR_EN;
            stp_err        <= ~sampled_bit;
            if (!(perr & PAR_EN) && sampled_bit) begin
              data_valid <= 1'b1;
              P_DATA     <= shift;
            end
          end
        end
        default: begin
          state          <= IDLE;
          data_sample_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural 3-sample majority
// sampler, directed frame table, hand-written corner sequences and random frames.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       data_sample_en;
  logic [4:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_IN          (RX_IN),
    .prescale       (prescale),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .sampled_bit    (sampled_bit),
    .data_sample_en (data_sample_en),
    .edge_cnt       (edge_cnt),
    .P_DATA         (P_DATA),
    .data_valid     (data_valid),
    .par_err        (par_err),
    .stp_err        (stp_err)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic int unsigned eff_of(input logic [5:0] p);
    if (p == 6'd16) return 16;
    if (p == 6'd32) return 32;
    return 8;
  endfunction

  // Majority sampler: captures at mid-1, mid, mid+1 of each bit.
  logic [2:0] smp = 3'b111;
  logic [4:0] mid;
  always_comb mid = 5'(eff_of(prescale) / 2);
  always @(posedge CLK) begin
    if (data_sample_en) begin
      if (edge_cnt == mid - 5'd1) smp[0] <= RX_IN;
      if (edge_cnt == mid)        smp[1] <= RX_IN;
      if (edge_cnt == mid + 5'd1) smp[2] <= RX_IN;
    end
  end
  assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  typedef struct packed {
    logic [31:0] cyc;
    logic        v;
    logic        pe;
    logic        se;
    logic [7:0]  d;
  } pulse_t;

  pulse_t got_q[$];
  pulse_t exp_q[$];

  // Record every output pulse cycle with its context.
  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err)
      got_q.push_back('{cyc: cyc, v: data_valid, pe: par_err, se: stp_err, d: P_DATA});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic compare_pulses(input string name);
    int unsigned n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int unsigned i = 0; i < n; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s[%0d]: got cyc=%0d v=%0b pe=%0b se=%0b d=%h want cyc=%0d v=%0b pe=%0b se=%0b d=%h",
                 name, i, got_q[i].cyc, got_q[i].v, got_q[i].pe, got_q[i].se, got_q[i].d,
                 exp_q[i].cyc, exp_q[i].v, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(input int unsigned eff, input logic [7:0] d, input logic pe,
                            input logic pbit, input logic sbit, output int unsigned t0);
    RX_IN = 1'b0;
    t0 = cyc + 1;
    repeat (eff) tick();
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (eff) tick();
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (eff) tick();
    end
    RX_IN = sbit;
    repeat (eff) tick();
    RX_IN = 1'b1;
  endtask

  // Pulse arrives after start + data + optional parity bits, plus the
  // stop-bit read point (mid + 2) and one register stage.
  function automatic int unsigned pulse_cycle(input int unsigned t0, input int unsigned eff,
                                              input logic pe);
    return t0 + eff * (pe ? 10 : 9) + eff / 2 + 3;
  endfunction

  logic [7:0] last_good;

  function automatic pulse_t model(input int unsigned t0, input int unsigned eff,
                                   input logic [7:0] d, input logic pe, input logic typ,
                                   input logic pbit, input logic sbit);
    logic want_par;
    logic pe_bad;
    logic ok;
    want_par = (^d) ^ typ;
    pe_bad   = pe && (pbit != want_par);
    ok       = !pe_bad && sbit;
    if (ok) last_good = d;
    return '{cyc: pulse_cycle(t0, eff, pe), v: ok, pe: pe_bad, se: !sbit, d: last_good};
  endfunction

  typedef struct {
    logic [5:0]  ps;
    logic        pe;
    logic        typ;
    logic [7:0]  data;
    logic        pbit;
    logic        sbit;
    int unsigned gap;
    logic        chk_after;
    logic        ev;
    logic        epe;
    logic        ese;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int unsigned t0;
    int unsigned eff;
    logic [5:0]  ps;
    logic        pe;
    logic        typ;
    logic [7:0]  d;
    logic        pbit;
    logic        sbit;

    tbl[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 10,  1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 10,  1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 10,  1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{6'd32, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 100, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[4] = '{6'd8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
    tbl[5] = '{6'd8,  1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 10,  1'b1, 1'b1, 1'b0, 1'b0, 8'hAA};
    tbl[6] = '{6'd5,  1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 10,  1'b1, 1'b1, 1'b0, 1'b0, 8'h12};

    RST = 1'b1; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) tick();
    chk("rst_valid", data_valid, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_serr", stp_err, 0);
    chk("rst_dse", data_sample_en, 0);
    chk("rst_edge", edge_cnt, 0);
    chk("rst_pdata", P_DATA, 0);
    RST = 1'b0;
    repeat (5) tick();

    // Directed frame table.
    for (int unsigned i = 0; i < 7; i++) begin
      prescale = tbl[i].ps; PAR_EN = tbl[i].pe; PAR_TYP = tbl[i].typ;
      eff = eff_of(tbl[i].ps);
      send_frame(eff, tbl[i].data, tbl[i].pe, tbl[i].pbit, tbl[i].sbit, t0);
      exp_q.push_back('{cyc: pulse_cycle(t0, eff, tbl[i].pe), v: tbl[i].ev,
                        pe: tbl[i].epe, se: tbl[i].ese, d: tbl[i].ed});
      repeat (tbl[i].gap) tick();
      if (tbl[i].chk_after) compare_pulses($sformatf("table%0d", i));
    end

    // Two-cycle low glitch at 16x: false start, sampler enable drops.
    prescale = 6'd16; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    t0 = cyc + 1;
    tick();
    chk("glitch_edge0", edge_cnt, 0);
    chk("glitch_dse_on", data_sample_en, 1);
    tick();
    RX_IN = 1'b1;
    while (cyc < t0 + 10) tick();
    chk("glitch_edge_read", edge_cnt, 10);
    chk("glitch_dse_read", data_sample_en, 1);
    tick();
    chk("glitch_dse_off", data_sample_en, 0);
    chk("glitch_edge_idle", edge_cnt, 0);
    repeat (30) tick();
    compare_pulses("glitch");

    // Reset during data bit 4, then a clean frame.
    prescale = 6'd8; PAR_EN = 1'b0;
    d = 8'h5A;
    RX_IN = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      repeat (8) tick();
    end
    RX_IN = d[4];
    repeat (3) tick();
    RST = 1'b1; RX_IN = 1'b1;
    tick();
    chk("midrst_valid", data_valid, 0);
    chk("midrst_perr", par_err, 0);
    chk("midrst_serr", stp_err, 0);
    chk("midrst_dse", data_sample_en, 0);
    chk("midrst_edge", edge_cnt, 0);
    chk("midrst_pdata", P_DATA, 0);
    RST = 1'b0;
    repeat (30) tick();
    compare_pulses("midrst_quiet");
    last_good = 8'h00;
    send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b1, t0);
    exp_q.push_back(model(t0, 8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (10) tick();
    compare_pulses("after_rst");

    // Random frames against the reference model.
    for (int unsigned n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: ps = 6'd8;
        1: ps = 6'd16;
        2: ps = 6'd32;
        default: ps = 6'($urandom_range(0, 63));
      endcase
      pe  = 1'($urandom_range(0, 1));
      typ = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      pbit = (^d) ^ typ;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 6) != 0);
      prescale = ps; PAR_EN = pe; PAR_TYP = typ;
      eff = eff_of(ps);
      send_frame(eff, d, pe, pbit, sbit, t0);
      exp_q.push_back(model(t0, eff, d, pe, typ, pbit, sbit));
      if (!sbit) repeat (3 * eff + 4) tick();
      else repeat ($urandom_range(0, 2)) tick();
    end
    repeat (80) tick();
    compare_pulses("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
